alu_lane_sequencer: RTL and testbench
=====================================

// Module: alu_lane_sequencer
// PURPOSE
//  Parametrised, registered successor to the combinational ALU-control decoder. Decodes opcode/funct/aluop
//  into a 4-bit ALU control word and issues it over a valid/ready beat stream. Scalar ops take 1 beat;
//  vector .fp ops take LANES beats with a lane index. vsum.fp also drives accumulator strobes.
//  Sits between the control unit and the lane-sliced SIMD ALU datapath.
// PARAMETERS
//  LANES    4                  number of vector lanes, >=2
//  LIDX_W   $clog2(LANES)      lane index width
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  flush       in   1       synchronous abort of current instruction
//  in_valid    in   1       decode request valid
//  in_ready    out  1       sequencer can accept a request
//  opcode      in   6       instruction opcode
//  funct       in   6       R-type function field
//  aluop       in   2       00 force add, 01 force sub, 1x use funct
//  out_valid   out  1       beat valid
//  out_ready   in   1       datapath accepts beat
//  alucontrol  out  4       ALU control word for this beat
//  lane_idx    out  LIDX_W  lane of this beat (0 for scalar)
//  lane_last   out  1       final beat of the instruction
//  is_vec      out  1       beat belongs to a vector op
//  acc_clear   out  1       vsum.fp: clear accumulator (first beat only)
//  acc_en      out  1       vsum.fp: accumulate this lane
// BEHAVIOUR
//  Decode, latched on accept (in_valid & in_ready):
//   arith opcodes 000000,010000,000100,001100; any other opcode -> 0100 (skip), scalar.
//   aluop 00 -> 0010 and aluop 01 -> 0110, both scalar. aluop 1x uses funct:
//   000000 0010, 000001 0110, 000010 1000, 000011 1001, 000101 1010, 000111 1011, 001000 1100,
//   000100 0010, 000110 0000 (all scalar);
//   100100 0010 vec, 100110 0000 vec, 110000 0011 vec+sum, 100101 0111 vec;
//   other funct -> 0100, scalar.
//  FSM: IDLE, ISSUE.
//   IDLE: out_valid=0, in_ready=1. On accept -> ISSUE. Beat 0 appears the next cycle (1-cycle latency).
//   ISSUE: out_valid=1. A beat retires when out_valid & out_ready.
//    Non-last beat retires: lane_idx += 1 the next cycle.
//    Last beat retires: lane_last=1 for scalar ops, and for vector ops when lane_idx==LANES-1.
//     If in_valid is high the same cycle, the new request is accepted; its beat 0 follows with no bubble.
//     Otherwise go to IDLE.
//  in_ready = (state==IDLE) | (out_valid & out_ready & lane_last) ; combinational.
//  Stall: while out_valid & !out_ready, all out_* signals hold stable.
//  alucontrol is constant for all beats of one instruction.
//  acc_clear = 1 only on lane 0 of vsum.fp. acc_en = 1 on every vsum.fp beat, 0 otherwise.
//  lane_idx counts 0..LANES-1 and never wraps inside an instruction. It resets to 0 on every accept.
//  flush: takes priority over everything. Next cycle: state=IDLE, out_valid=0, lane_idx=0.
//   Any request offered in the flush cycle is not accepted.
//  Reset (async, any time incl. mid-vector): state=IDLE, out_valid=0, alucontrol=4'b0100, lane_idx=0,
//   lane_last=0, is_vec=0, acc_clear=0, acc_en=0. in_ready=1 after reset release.
// TESTING
//  1. opcode 000000, aluop 10, funct 001000, out_ready=1 -> one beat next cycle: alucontrol=1100,
//     lane_last=1, is_vec=0.
//  2. funct 100110, LANES=4, out_ready=1 -> 4 consecutive beats alucontrol=0000, lane_idx 0..3,
//     lane_last only on 3, in_ready low during beats 0..2.
//  3. vsum.fp (funct 110000) with out_ready low on beat 1 for 3 cycles -> beat 1 held stable;
//     acc_clear only on lane 0; acc_en on all 4 beats.
//  4. Back-to-back: scalar add then vadd.fp presented during the last beat -> no idle cycle between
//     them; vadd beat 0 has lane_idx=0.
//  5. Non-arith opcode 100011 -> alucontrol=0100 single beat. aluop 01 with funct 100100 -> 0110 scalar.
//  6. rst_n low at lane 2 of vmul.fp -> out_valid=0, alucontrol=0100 immediately.
//     flush at lane 1 -> IDLE next cycle, in_ready=1.

Source files
------------

// File: rtl/alu_lane_sequencer_if.sv
// Request and beat stream bundle between the control unit, the lane sequencer and the SIMD ALU datapath.
interface alu_lane_sequencer_if #(
  parameter int LIDX_W = 2
);

  logic              in_valid;
  logic              in_ready;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [1:0]        aluop;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        alucontrol;
  logic [LIDX_W-1:0] lane_idx;
  logic              lane_last;
  logic              is_vec;
  logic              acc_clear;
  logic              acc_en;

  modport master (
    output in_valid, opcode, funct, aluop, out_ready,
    input  in_ready, out_valid, alucontrol, lane_idx, lane_last, is_vec, acc_clear, acc_en
  );

  modport slave (
    input  in_valid, opcode, funct, aluop, out_ready,
    output in_ready, out_valid, alucontrol, lane_idx, lane_last, is_vec, acc_clear, acc_en
  );

endinterface

// File: rtl/alu_lane_sequencer.sv
// Registered ALU-control decoder: scalar ops issue one beat, vector .fp ops issue LANES
// lane-indexed beats over a valid/ready stream, with accumulator strobes for vsum.fp.
module alu_lane_sequencer #(
  parameter int LANES  = 4,
  parameter int LIDX_W = $clog2(LANES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  alu_lane_sequencer_if.slave bus
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

  // Returns {alucontrol[3:0], vector, vsum}.
  function automatic logic [5:0] f_decode(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [1:0] aop);
    logic [3:0] ctrl;
    logic       vec;
    logic       sum;
    ctrl = 4'b0100;
    vec  = 1'b0;
    sum  = 1'b0;
    case (op)
      6'b000000, 6'b010000, 6'b000100, 6'b001100: begin
        if (aop == 2'b00) begin
          ctrl = 4'b0010;
        end else if (aop == 2'b01) begin
          ctrl = 4'b0110;
        end else begin
          case (fn)
            6'b000000: ctrl = 4'b0010;
            6'b000001: ctrl = 4'b0110;
            6'b000010: ctrl = 4'b1000;
            6'b000011: ctrl = 4'b1001;
            6'b000101: ctrl = 4'b1010;
            6'b000111: ctrl = 4'b1011;
            6'b001000: ctrl = 4'b1100;
            6'b000100: ctrl = 4'b0010;
            6'b000110: ctrl = 4'b0000;
            6'b100100: begin ctrl = 4'b0010; vec = 1'b1; end
            6'b100110: begin ctrl = 4'b0000; vec = 1'b1; end
            6'b110000: begin ctrl = 4'b0011; vec = 1'b1; sum = 1'b1; end
            6'b100101: begin ctrl = 4'b0111; vec = 1'b1; end
            default:   ctrl = 4'b0100;
          endcase
        end
      end
      default: ctrl = 4'b0100;
    endcase
    return {ctrl, vec, sum};
  endfunction

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_alucontrol, w_alucontrol_nxt;
  logic [LIDX_W-1:0] r_lane_idx, w_lane_idx_nxt, w_lane_inc;
  logic              r_lane_last, w_lane_last_nxt;
  logic              r_is_vec, w_is_vec_nxt;
  logic              r_acc_clear, w_acc_clear_nxt;
  logic              r_acc_en, w_acc_en_nxt;
  logic              w_in_ready, w_accept, w_retire, w_load;
  logic [5:0]        w_dec;

  assign w_retire   = (r_state == S_ISSUE) & bus.out_ready;
  // A request offered during flush must not look accepted upstream.
  assign w_in_ready = ~flush & ((r_state == S_IDLE) | (w_retire & r_lane_last));
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_dec      = f_decode(bus.opcode, bus.funct, bus.aluop);
  assign w_lane_inc = r_lane_idx + LIDX_W'(1);

  // Next-state and next-beat computation.
  always_comb begin
    w_state_nxt      = r_state;
    w_alucontrol_nxt = r_alucontrol;
    w_lane_idx_nxt   = r_lane_idx;
    w_lane_last_nxt  = r_lane_last;
    w_is_vec_nxt     = r_is_vec;
    w_acc_clear_nxt  = r_acc_clear;
    w_acc_en_nxt     = r_acc_en;
    w_load           = 1'b0;
    if (flush) begin
      w_state_nxt     = S_IDLE;
      w_lane_idx_nxt  = '0;
      w_lane_last_nxt = 1'b0;
      w_acc_clear_nxt = 1'b0;
      w_acc_en_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_load = w_accept;
        end
        S_ISSUE: begin
          if (w_retire && r_lane_last) begin
            w_load          = w_accept;
            w_state_nxt     = S_IDLE;
            w_lane_last_nxt = 1'b0;
            w_acc_clear_nxt = 1'b0;
            w_acc_en_nxt    = 1'b0;
          end else if (w_retire) begin
            w_lane_idx_nxt  = w_lane_inc;
            w_lane_last_nxt = (w_lane_inc == LAST_LANE);
            w_acc_clear_nxt = 1'b0;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_load) begin
        w_state_nxt      = S_ISSUE;
        w_alucontrol_nxt = w_dec[5:2];
        w_is_vec_nxt     = w_dec[1];
        w_lane_idx_nxt   = '0;
        w_lane_last_nxt  = ~w_dec[1];
        w_acc_clear_nxt  = w_dec[0];
        w_acc_en_nxt     = w_dec[0];
      end else begin
        w_load = 1'b0;
      end
    end
  end

  // State and beat registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_alucontrol <= 4'b0100;
      r_lane_idx   <= '0;
      r_lane_last  <= 1'b0;
      r_is_vec     <= 1'b0;
      r_acc_clear  <= 1'b0;
      r_acc_en     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_alucontrol <= w_alucontrol_nxt;
      r_lane_idx   <= w_lane_idx_nxt;
      r_lane_last  <= w_lane_last_nxt;
      r_is_vec     <= w_is_vec_nxt;
      r_acc_clear  <= w_acc_clear_nxt;
      r_acc_en     <= w_acc_en_nxt;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == S_ISSUE);
  assign bus.alucontrol = r_alucontrol;
  assign bus.lane_idx   = r_lane_idx;
  assign bus.lane_last  = r_lane_last;
  assign bus.is_vec     = r_is_vec;
  assign bus.acc_clear  = r_acc_clear;
  assign bus.acc_en     = r_acc_en;

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// Randomized bench for alu_lane_sequencer: a queue of expected beats built from the decode
// table is compared against the beat stream every cycle.
module tb_alu_lane_sequencer;

  localparam int LANES  = 4;
  localparam int LIDX_W = $clog2(LANES);

  localparam logic [5:0] FN_TAB [13] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000101,
                                         6'b000111, 6'b001000, 6'b000100, 6'b000110, 6'b100100,
                                         6'b100110, 6'b110000, 6'b100101};
  localparam logic [3:0] CT_TAB [13] = '{4'b0010, 4'b0110, 4'b1000, 4'b1001, 4'b1010,
                                         4'b1011, 4'b1100, 4'b0010, 4'b0000, 4'b0010,
                                         4'b0000, 4'b0011, 4'b0111};
  localparam logic [5:0] ARITH [4]   = '{6'b000000, 6'b010000, 6'b000100, 6'b001100};

  typedef struct packed {
    logic [3:0]        ctrl;
    logic [LIDX_W-1:0] idx;
    logic              last;
    logic              vec;
    logic              clr;
    logic              en;
  } beat_t;

  logic  clk;
  logic  rst_n;
  logic  flush;
  int    n_tests;
  int    n_fail;
  beat_t exp_q[$];

  alu_lane_sequencer_if #(.LIDX_W(LIDX_W)) bus ();

  alu_lane_sequencer #(.LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected beats of one instruction, straight from the decode table.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] aop);
    logic [3:0] c;
    logic       v;
    logic       s;
    beat_t      b;
    c = 4'b0100;
    v = 1'b0;
    s = 1'b0;
    if (op inside {ARITH[0], ARITH[1], ARITH[2], ARITH[3]}) begin
      if (aop == 2'b00) c = 4'b0010;
      else if (aop == 2'b01) c = 4'b0110;
      else begin
        for (int k = 0; k < 13; k++) begin
          if (FN_TAB[k] == fn) begin
            c = CT_TAB[k];
            v = (fn[5] == 1'b1);
            s = (fn == 6'b110000);
          end
        end
      end
    end
    for (int i = 0; i < (v ? LANES : 1); i++) begin
      b.ctrl = c;
      b.idx  = LIDX_W'(i);
      b.last = (i == (v ? LANES : 1) - 1);
      b.vec  = v;
      b.clr  = s && (i == 0);
      b.en   = s;
      exp_q.push_back(b);
    end
  endtask

  // One clock: drive inputs, compare outputs, then advance the model on the edge.
  task automatic run_cycle(input logic iv, input logic [5:0] op, input logic [5:0] fn,
                           input logic [1:0] aop, input logic ordy, input logic fl);
    logic  exp_valid;
    logic  exp_rdy;
    beat_t b;
    bus.in_valid  = iv;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.aluop     = aop;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_rdy   = (exp_q.size() == 0) || (ordy && exp_q.size() == 1);
    check_val("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    if (!fl) check_val("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (exp_valid) begin
      b = exp_q[0];
      check_val("alucontrol", 32'(bus.alucontrol), 32'(b.ctrl));
      check_val("lane_idx",   32'(bus.lane_idx),   32'(b.idx));
      check_val("lane_last",  32'(bus.lane_last),  32'(b.last));
      check_val("is_vec",     32'(bus.is_vec),     32'(b.vec));
      check_val("acc_clear",  32'(bus.acc_clear),  32'(b.clr));
      check_val("acc_en",     32'(bus.acc_en),     32'(b.en));
    end
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_valid && ordy) b = exp_q.pop_front();
      if (iv && exp_rdy) push_instr(op, fn, aop);
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(bus.out_valid),  32'd0);
    check_val({tag, "_ctrl"},  32'(bus.alucontrol), 32'h4);
    check_val({tag, "_idx"},   32'(bus.lane_idx),   32'd0);
    check_val({tag, "_last"},  32'(bus.lane_last),  32'd0);
    check_val({tag, "_vec"},   32'(bus.is_vec),     32'd0);
    check_val({tag, "_clr"},   32'(bus.acc_clear),  32'd0);
    check_val({tag, "_en"},    32'(bus.acc_en),     32'd0);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opcode    = 6'd0;
    bus.funct     = 6'd0;
    bus.aluop     = 2'b00;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Scalar slt-style op (funct 001000).
    run_cycle(1'b1, 6'b000000, 6'b001000, 2'b10, 1'b1, 1'b0);
    run_cycle(1'b0, 6'b000000, 6'b000000, 2'b10, 1'b1, 1'b0);
    run_cycle(1'b0, 6'b000000, 6'b000000, 2'b10, 1'b1, 1'b0);

    // Four-beat vector op.
    run_cycle(1'b1, 6'b000000, 6'b100110, 2'b10, 1'b1, 1'b0);
    repeat (5) run_cycle(1'b0, 6'b000000, 6'b000000, 2'b10, 1'b1, 1'b0);

    // vsum.fp with beat 1 stalled three cycles.
    run_cycle(1'b1, 6'b000000, 6'b110000, 2'b10, 1'b1, 1'b0);
    run_cycle(1'b0, 6'b000000, 6'b000000, 2'b10, 1'b1, 1'b0);
    repeat (3) run_cycle(1'b0, 6'b000000, 6'b000000, 2'b10, 1'b0, 1'b0);
    repeat (4) run_cycle(1'b0, 6'b000000, 6'b000000, 2'b10, 1'b1, 1'b0);

    // Scalar add followed back-to-back by vadd.fp offered on its last beat.
    run_cycle(1'b1, 6'b000000, 6'b000000, 2'b10, 1'b1, 1'b0);
    run_cycle(1'b1, 6'b000000, 6'b100100, 2'b10, 1'b1, 1'b0);
    repeat (5) run_cycle(1'b0, 6'b000000, 6'b000000, 2'b10, 1'b1, 1'b0);

    // Non-arith opcode and forced subtract.
    run_cycle(1'b1, 6'b100011, 6'b000000, 2'b10, 1'b1, 1'b0);
    run_cycle(1'b1, 6'b000000, 6'b100100, 2'b01, 1'b1, 1'b0);
    repeat (2) run_cycle(1'b0, 6'b000000, 6'b000000, 2'b10, 1'b1, 1'b0);

    // Asynchronous reset while vmul.fp is on lane 2.
    run_cycle(1'b1, 6'b000000, 6'b100101, 2'b10, 1'b1, 1'b0);
    repeat (2) run_cycle(1'b0, 6'b000000, 6'b000000, 2'b10, 1'b1, 1'b0);
    check_val("pre_rst_idx", 32'(bus.lane_idx), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_rdy", 32'(bus.in_ready), 32'd1);

    // Flush on lane 1 with a competing request that must be dropped.
    run_cycle(1'b1, 6'b000000, 6'b100101, 2'b10, 1'b1, 1'b0);
    run_cycle(1'b0, 6'b000000, 6'b000000, 2'b10, 1'b1, 1'b0);
    run_cycle(1'b1, 6'b000000, 6'b100100, 2'b10, 1'b0, 1'b1);
    run_cycle(1'b0, 6'b000000, 6'b000000, 2'b10, 1'b1, 1'b0);

    // Random traffic with stalls, back-to-back requests and occasional flushes.
    for (int n = 0; n < 600; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      logic [1:0] aop;
      op  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ARITH[$urandom_range(0, 3)];
      fn  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : FN_TAB[$urandom_range(0, 12)];
      aop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      run_cycle($urandom_range(0, 9) < 6, op, fn, aop,
                $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
